// File: rtl/layer_seq.sv
// Layer sequencer: walks a host-programmed descriptor table and issues one
// request per layer to the conv core, ping-ponging the image buffer bases.
module layer_seq #(
    parameter int LWIDTH   = 16,
    parameter int IMGSIZE  = 12,
    parameter int NETSIZE  = 14,
    parameter int NLAYER   = 8,
    parameter int LAYERLOG = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [LAYERLOG-1:0] cfg_layer,
    input  logic [2:0]          cfg_field,
    input  logic [NETSIZE-1:0]  cfg_data,
    input  logic                start,
    input  logic [LAYERLOG:0]   num_layers,
    input  logic [IMGSIZE-1:0]  base_a,
    input  logic [IMGSIZE-1:0]  base_b,
    input  logic                ack,
    output logic                req,
    output logic [LWIDTH-1:0]   total_out,
    output logic [LWIDTH-1:0]   total_in,
    output logic [LWIDTH-1:0]   img_size,
    output logic [LWIDTH-1:0]   fil_size,
    output logic [NETSIZE-1:0]  net_addr,
    output logic [IMGSIZE-1:0]  input_addr,
    output logic [IMGSIZE-1:0]  output_addr,
    output logic                busy,
    output logic                done,
    output logic [LAYERLOG-1:0] cur_layer,
    output logic                cfg_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_WAIT_LO = 3'd3;
    localparam logic [2:0] S_WAIT_HI = 3'd4;
    localparam logic [2:0] S_FIN     = 3'd5;

    localparam int DW = (NETSIZE > LWIDTH) ? NETSIZE : LWIDTH;
    localparam logic [LAYERLOG:0] NL_ONE = 1;

    logic [2:0]          state;
    logic [LAYERLOG-1:0] layer;
    logic [LAYERLOG:0]   nl_q;
    logic [IMGSIZE-1:0]  base_a_q;
    logic [IMGSIZE-1:0]  base_b_q;
    logic [1:0]          to_cnt;
    logic                last_layer;
    logic [DW-1:0]       wdata;

    logic [LWIDTH-1:0]  tout_mem [NLAYER];
    logic [LWIDTH-1:0]  tin_mem  [NLAYER];
    logic [LWIDTH-1:0]  img_mem  [NLAYER];
    logic [LWIDTH-1:0]  fil_mem  [NLAYER];
    logic [NETSIZE-1:0] net_mem  [NLAYER];

    // Narrow cfg_data is zero-extended into the wider LWIDTH fields.
    assign wdata      = DW'(cfg_data);
    assign last_layer = ({1'b0, layer} == (nl_q - NL_ONE));

    // Descriptor table: not reset, writes only while idle.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy) begin
            case (cfg_field)
                3'd0:    tout_mem[cfg_layer] <= wdata[LWIDTH-1:0];
                3'd1:    tin_mem[cfg_layer]  <= wdata[LWIDTH-1:0];
                3'd2:    img_mem[cfg_layer]  <= wdata[LWIDTH-1:0];
                3'd3:    fil_mem[cfg_layer]  <= wdata[LWIDTH-1:0];
                3'd4:    net_mem[cfg_layer]  <= wdata[NETSIZE-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            layer       <= '0;
            nl_q        <= '0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            to_cnt      <= '0;
            req         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
            total_out   <= '0;
            total_in    <= '0;
            img_size    <= '0;
            fil_size    <= '0;
            net_addr    <= '0;
            input_addr  <= '0;
            output_addr <= '0;
            cur_layer   <= '0;
        end else begin
            req     <= 1'b0;
            done    <= 1'b0;
            cfg_err <= cfg_we && busy;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        nl_q     <= num_layers;
                        base_a_q <= base_a;
                        base_b_q <= base_b;
                        layer    <= '0;
                        busy     <= 1'b1;
                        state    <= (num_layers == '0) ? S_FIN : S_LOAD;
                    end
                end
                S_LOAD: begin
                    total_out   <= tout_mem[layer];
                    total_in    <= tin_mem[layer];
                    img_size    <= img_mem[layer];
                    fil_size    <= fil_mem[layer];
                    net_addr    <= net_mem[layer];
                    input_addr  <= layer[0] ? base_b_q : base_a_q;
                    output_addr <= layer[0] ? base_a_q : base_b_q;
                    cur_layer   <= layer;
                    state       <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (ack) begin
                        req    <= 1'b1;
                        to_cnt <= '0;
                        state  <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    // A core that never drops ack is taken as having finished.
                    if (!ack || to_cnt == 2'd3) begin
                        state <= S_WAIT_HI;
                    end else begin
                        to_cnt <= to_cnt + 2'd1;
                    end
                end
                S_WAIT_HI: begin
                    if (ack) begin
                        if (last_layer) begin
                            state <= S_FIN;
                        end else begin
                            layer <= layer + LAYERLOG'(1);
                            state <= S_LOAD;
                        end
                    end
                end
                S_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_seq.sv
// Testbench for layer_seq: core ack model, descriptor model and a scoreboard
// of expected per-layer request parameters.
module tb_layer_seq;

    typedef struct packed {
        logic [15:0] to;
        logic [15:0] ti;
        logic [15:0] is;
        logic [15:0] fs;
        logic [13:0] na;
        logic [11:0] ia;
        logic [11:0] oa;
        logic [2:0]  cl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_layer;
    logic [2:0]  cfg_field;
    logic [13:0] cfg_data;
    logic        start;
    logic [3:0]  num_layers;
    logic [11:0] base_a;
    logic [11:0] base_b;
    logic        ack;
    logic        req;
    logic [15:0] total_out;
    logic [15:0] total_in;
    logic [15:0] img_size;
    logic [15:0] fil_size;
    logic [13:0] net_addr;
    logic [11:0] input_addr;
    logic [11:0] output_addr;
    logic        busy;
    logic        done;
    logic [2:0]  cur_layer;
    logic        cfg_err;

    int vectors = 0;
    int miscompares = 0;
    int req_cnt = 0;

    exp_t sb[$];
    exp_t e_mon;
    exp_t act_mon;

    logic [15:0] m_to [8];
    logic [15:0] m_ti [8];
    logic [15:0] m_is [8];
    logic [15:0] m_fs [8];
    logic [13:0] m_na [8];

    int   lat = 3;
    bit   hold_lo = 0;
    bit   core_ack;
    bit   pend;
    int   core_cnt;

    layer_seq dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_layer(cfg_layer),
        .cfg_field(cfg_field), .cfg_data(cfg_data), .start(start),
        .num_layers(num_layers), .base_a(base_a), .base_b(base_b), .ack(ack),
        .req(req), .total_out(total_out), .total_in(total_in),
        .img_size(img_size), .fil_size(fil_size), .net_addr(net_addr),
        .input_addr(input_addr), .output_addr(output_addr), .busy(busy),
        .done(done), .cur_layer(cur_layer), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Core model: drops ack the cycle after req, holds it low for lat cycles.
    initial begin
        ack = 1'b1; core_ack = 1'b1; pend = 1'b0; core_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                core_cnt = 0; pend = 1'b0; core_ack = 1'b1;
            end else begin
                if (core_cnt > 0) begin
                    core_cnt--;
                    if (core_cnt == 0) core_ack = 1'b1;
                end else if (pend) begin
                    pend = 1'b0; core_ack = 1'b0; core_cnt = lat;
                end
                if (req) pend = 1'b1;
            end
            ack = core_ack && !hold_lo;
        end
    end

    // Scoreboard: every req must match the next expected layer descriptor.
    always @(negedge clk) begin
        if (req === 1'b1) begin
            req_cnt++;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL req_unexpected: got req for cur_layer=%0d, required no req", cur_layer);
            end else begin
                e_mon = sb.pop_front();
                act_mon = {total_out, total_in, img_size, fil_size, net_addr,
                           input_addr, output_addr, cur_layer};
                if (act_mon !== e_mon) begin
                    miscompares++;
                    $display("FAIL req_params: got %h, required %h", act_mon, e_mon);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic cfg_write(input int l, input int f, input int d, input bit upd);
        @(negedge clk);
        cfg_we = 1'b1; cfg_layer = 3'(l); cfg_field = 3'(f); cfg_data = 14'(d);
        @(negedge clk);
        cfg_we = 1'b0;
        if (upd) begin
            case (f)
                0: m_to[l] = 16'(d);
                1: m_ti[l] = 16'(d);
                2: m_is[l] = 16'(d);
                3: m_fs[l] = 16'(d);
                4: m_na[l] = 14'(d);
                default: ;
            endcase
        end
    endtask

    task automatic write_layer(input int l, input int to, input int ti,
                               input int is, input int fs, input int na);
        cfg_write(l, 0, to, 1);
        cfg_write(l, 1, ti, 1);
        cfg_write(l, 2, is, 1);
        cfg_write(l, 3, fs, 1);
        cfg_write(l, 4, na, 1);
    endtask

    task automatic push_run(input int n, input logic [11:0] a, input logic [11:0] b);
        for (int i = 0; i < n; i++) begin
            sb.push_back(exp_t'({m_to[i], m_ti[i], m_is[i], m_fs[i], m_na[i],
                                 (i % 2 == 1) ? b : a, (i % 2 == 1) ? a : b, 3'(i)}));
        end
    endtask

    task automatic run(input int n, input logic [11:0] a, input logic [11:0] b);
        @(negedge clk);
        start = 1'b1; num_layers = 4'(n); base_a = a; base_b = b;
        push_run(n, a, b);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({req, busy, done, cfg_err, total_out, total_in, img_size, fil_size,
             net_addr, input_addr, output_addr, cur_layer} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got req=%b busy=%b done=%b, required all outputs 0", req, busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({req, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_release: got req/busy/done=%b, required 000", {req, busy, done});
        end
    endtask

    task automatic test_single();
        int r0; bit got;
        write_layer(0, 32, 1, 12, 5, 'h40);
        lat = 3;
        r0 = req_cnt;
        run(1, 12'h000, 12'h400);
        wait_done(60, got);
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL single_done: got no done pulse, required one within 60 cycles");
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_busy: got busy=%b at done, required 0", busy);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done_width: got done=%b second cycle, required 0", done);
        end
        #1;
        vectors++;
        if (req_cnt - r0 != 1 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL single_req_count: got %0d reqs (%0d pending), required 1 (0)", req_cnt - r0, sb.size());
        end
    endtask

    task automatic test_three();
        int r0; bit got;
        write_layer(0, 10, 3, 28, 3, 'h100);
        write_layer(1, 20, 10, 14, 3, 'h200);
        write_layer(2, 40, 20, 7, 1, 'h3ff);
        lat = 20;
        r0 = req_cnt;
        run(3, 12'h100, 12'h800);
        wait_done(300, got);
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL three_done: got no done pulse, required one within 300 cycles");
        end
        repeat (5) @(negedge clk);
        #1;
        vectors++;
        if (req_cnt - r0 != 3 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL three_req_count: got %0d reqs (%0d pending), required 3 (0)", req_cnt - r0, sb.size());
        end
    endtask

    task automatic test_zero();
        int r0;
        r0 = req_cnt;
        @(negedge clk);
        start = 1'b1; num_layers = 4'd0; base_a = 12'h111; base_b = 12'h222;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if ({busy, done} !== 2'b10) begin
            miscompares++;
            $display("FAIL zero_first_cycle: got busy/done=%b, required 10", {busy, done});
        end
        @(negedge clk);
        vectors++;
        if ({busy, done} !== 2'b01) begin
            miscompares++;
            $display("FAIL zero_done: got busy/done=%b two cycles after start, required 01", {busy, done});
        end
        #1;
        vectors++;
        if (req_cnt != r0) begin
            miscompares++;
            $display("FAIL zero_no_req: got %0d reqs, required 0", req_cnt - r0);
        end
    endtask

    task automatic test_ack_held();
        int r0; bit got; bit seen;
        lat = 4;
        hold_lo = 1'b1;
        r0 = req_cnt;
        run(1, 12'h0a0, 12'h0b0);
        repeat (10) @(negedge clk);
        #1;
        vectors++;
        if (req_cnt != r0) begin
            miscompares++;
            $display("FAIL ack_held_withheld: got %0d reqs while ack low, required 0", req_cnt - r0);
        end
        hold_lo = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (req_cnt != r0) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL ack_held_release: got no req within 4 cycles of ack=1, required req");
        end
        wait_done(60, got);
        vectors++;
        if (!got || sb.size() != 0) begin
            miscompares++;
            $display("FAIL ack_held_done: got done=%b pending=%0d, required done and 0 pending", got, sb.size());
        end
    endtask

    task automatic test_start_with_cfg();
        bit got;
        lat = 2;
        @(negedge clk);
        start = 1'b1; num_layers = 4'd1; base_a = 12'h300; base_b = 12'h500;
        cfg_we = 1'b1; cfg_layer = 3'd0; cfg_field = 3'd1; cfg_data = 14'd7;
        m_ti[0] = 16'd7;
        push_run(1, 12'h300, 12'h500);
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0;
        vectors++;
        if (cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL start_cfg_err: got cfg_err=%b for idle write, required 0", cfg_err);
        end
        wait_done(60, got);
        vectors++;
        if (!got || sb.size() != 0) begin
            miscompares++;
            $display("FAIL start_cfg_done: got done=%b pending=%0d, required done and 0 pending", got, sb.size());
        end
    endtask

    task automatic test_cfg_during_run();
        int r0; bit got;
        lat = 20;
        r0 = req_cnt;
        run(2, 12'h100, 12'h200);
        cfg_write(0, 0, 'h3ff, 0);
        vectors++;
        if (cfg_err !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_cfg_err: got cfg_err=%b, required 1", cfg_err);
        end
        @(negedge clk);
        vectors++;
        if (cfg_err !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_cfg_err_width: got cfg_err=%b second cycle, required 0", cfg_err);
        end
        start = 1'b1; num_layers = 4'd1; base_a = 12'h777; base_b = 12'h666;
        @(negedge clk);
        start = 1'b0;
        wait_done(300, got);
        repeat (10) @(negedge clk);
        #1;
        vectors++;
        if (!got || req_cnt - r0 != 2 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL busy_start_ignored: got done=%b reqs=%0d, required done and 2 reqs", got, req_cnt - r0);
        end
        lat = 3;
        run(1, 12'h000, 12'h100);
        wait_done(60, got);
        vectors++;
        if (!got || sb.size() != 0) begin
            miscompares++;
            $display("FAIL busy_rerun: got done=%b pending=%0d, required done and 0 pending", got, sb.size());
        end
    endtask

    task automatic test_rst_mid();
        int r0; bit seen; bit got;
        lat = 20;
        r0 = req_cnt;
        run(2, 12'h010, 12'h020);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (req_cnt - r0 >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL rst_mid_layer1_req: got %0d reqs, required 2", req_cnt - r0);
        end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({req, busy, done, cfg_err, total_out, total_in, img_size, fil_size,
             net_addr, input_addr, output_addr, cur_layer} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got busy=%b cur_layer=%0d net_addr=%h, required all 0", busy, cur_layer, net_addr);
        end
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        lat = 3;
        run(1, 12'h030, 12'h040);
        wait_done(60, got);
        vectors++;
        if (!got || sb.size() != 0) begin
            miscompares++;
            $display("FAIL rst_mid_rerun: got done=%b pending=%0d, required done and 0 pending", got, sb.size());
        end
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_layer = '0; cfg_field = '0; cfg_data = '0;
        start = 1'b0; num_layers = '0; base_a = '0; base_b = '0;
        test_reset();
        test_single();
        test_three();
        test_zero();
        test_ack_held();
        test_start_with_cfg();
        test_cfg_during_run();
        test_rst_mid();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
